dmi_responder: RTL and testbench
================================

# dmi_responder

Debug-module-side responder for the DMI link driven by the `dmi_jtag` transport. It accepts DMI read/write requests and returns exactly one response per request. Its register set covers dmcontrol, dmstatus, abstractcs, command, the data registers and authdata. It turns register writes into hart-side halt/resume/reset controls and a handshaked abstract-command port, and sits between `dmi_jtag` and the Ariane core's debug inputs.

## Interface
- NB_DATA, 2: number of data registers (data0..dataN-1 at 0x04..); legal range 1-12.
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- dmi_req_i  in  41  dm::dmi_req_t: addr[6:0], op[1:0] (0 NOP, 1 READ, 2 WRITE, 3 reserved), data[31:0]
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request ready
- dmi_resp_o  out  34  dm::dmi_resp_t: data[31:0], resp[1:0] (0 OK, 2 FAILED, 3 BUSY)
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response ready
- halted_i  in  1  hart halted status
- debug_req_o  out  1  haltreq level to the core
- resume_o  out  1  one-cycle resume pulse
- ndmreset_o  out  1  non-debug-module reset
- dmactive_o  out  1  dmcontrol.dmactive
- cmd_valid_o, cmd_ready_i  out/in  1  abstract command handshake
- cmd_o  out  32  latched command word
- cmd_done_i  in  1  one-cycle completion strobe
- cmd_err_i  in  3  error code, sampled together with cmd_done_i
- auth_key_i  in  32  authentication key; present only with DMI_AUTH_EN

## Operation
- Register map:
  - dmcontrol 0x10: bit 31 haltreq, bit 30 resumereq, bit 1 ndmreset, bit 0 dmactive.
  - dmstatus 0x11 (RO): version[3:0]=2, authenticated[7], anyhalted[8], allhalted[9], anyrunning[10], allrunning[11], anyresumeack[16], allresumeack[17].
  - abstractcs 0x16: datacount[3:0]=NB_DATA, cmderr[10:8] (write-1-to-clear), busy[12], progbufsize[28:24]=0.
  - command 0x17 (WO, reads 0).
  - authdata 0x30.
  - Unmapped addresses read 0; writes to them are ignored; resp OK.
- Reserved op (3): resp FAILED, no side effects. NOP: resp OK, data 0.
- dmactive=0: all other state is held at reset values. Only dmcontrol.dmactive is writable.
- resumereq written 1 with halted_i=1: resume_o pulses the next cycle and resumeack is cleared. resumeack sets on the first cycle where halted_i=0 after that pulse.
- haltreq drives debug_req_o directly.
- Abstract command FSM, in sub-module dmi_abstract_cmd, with states CMD_IDLE, CMD_ISSUE, CMD_WAIT:
  - Command write in CMD_IDLE with cmderr=0: latch the word, busy=1, go to CMD_ISSUE.
  - CMD_ISSUE: cmd_valid_o=1 until cmd_ready_i, then go to CMD_WAIT.
  - CMD_WAIT: on cmd_done_i, cmderr |= cmd_err_i, busy=0, return to CMD_IDLE.
  - Command write while cmderr≠0: ignored, resp OK.
- Busy access rule: while busy=1, any access to data*, command or abstractcs writes returns resp BUSY and is ignored. In that case cmderr is set to 1 if it was 0.
- cmd_done_i in the same cycle as a command write: the write sees busy=1 and gets the BUSY treatment above.

## Timing
- Response FSM states: IDLE, RESP.
- dmi_req_ready_o=1 only in IDLE.
- Request accepted (valid&ready) in cycle N: the register is read/written in cycle N, and dmi_resp_valid_o=1 from N+1.
- Response payload is stable while valid=1 and ready=0. The block returns to IDLE in the cycle ready=1.
- Maximum throughput: one request every 2 cycles.
- Reset values: all outputs 0 (dmi_req_ready_o rises the cycle after rst_i deasserts). All registers 0, cmd FSM in CMD_IDLE.
- rst_i asserted mid-response: the response is dropped, no replay. An abstract command in flight is abandoned; late cmd_done_i is ignored.

## Configuration
- DMI_AUTH_EN defined:
  - authenticated resets to 0.
  - Writing authdata equal to auth_key_i sets authenticated=1. A mismatch leaves it 0 (resp OK).
  - authdata reads return 0.
  - While unauthenticated, reads of any register other than dmstatus and authdata return 0. Writes other than dmcontrol.dmactive and authdata are ignored.
  - dmactive=0 clears authenticated.
- DMI_AUTH_EN undefined: the auth_key_i port is absent, authenticated is constant 1, and authdata reads 0 and ignores writes.

## Structure
- The dm package holds dmi_req_t/dmi_resp_t, the op and resp encodings, the register address localparams, and a cmderr enum (NONE=0, BUSY=1, NOTSUP=2, EXCEPTION=3, HALTRESUME=4, BUS=5, OTHER=7).
- Sub-module dmi_abstract_cmd holds the command FSM, busy and cmderr. The top holds the response FSM and the registers.

## Test plan
- Reset, then READ dmstatus (0x11) with halted_i=0: resp OK, data 0x00000C82 with auth disabled (version 2, authenticated, allrunning/anyrunning set).
- WRITE dmcontrol 0x80000001, then READ dmcontrol: debug_req_o=1, dmactive_o=1, readback 0x80000001. Hold dmi_resp_ready_i low 5 cycles: payload stable, no new request accepted.
- With dmactive=1, WRITE command 0x00221000:
  - cmd_valid_o rises, cmd_o=0x00221000.
  - Before cmd_done_i, WRITE data0 → resp BUSY, and abstractcs reads cmderr=1, busy=1.
  - cmd_done_i with cmd_err_i=0: busy=0.
  - WRITE abstractcs 0x700: cmderr clears to 0.
- op=3 to 0x10: resp FAILED, dmcontrol unchanged. READ 0x7F: data 0, resp OK.
- With halted_i=1, WRITE dmcontrol 0x40000001: one-cycle resume_o. Drop halted_i: dmstatus allresumeack=1.
- DMI_AUTH_EN defined, auth_key_i=0xDEADBEEF:
  - WRITE authdata 0x12345678: authenticated stays 0.
  - WRITE dmcontrol 0x80000001: only dmactive set.
  - WRITE authdata 0xDEADBEEF: authenticated=1, and the haltreq write now takes effect.

Source files
------------

// File: rtl/dmi_responder_pkg.sv
// Shared DMI types, encodings and register addresses for the debug-module responder.
package dmi_responder_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } dmi_resp_t;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OK     = 2'd0;
    localparam logic [1:0] RESP_FAILED = 2'd2;
    localparam logic [1:0] RESP_BUSY   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_DATA0      = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [ADDR_W-1:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [ADDR_W-1:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [ADDR_W-1:0] ADDR_COMMAND    = 7'h17;
    localparam logic [ADDR_W-1:0] ADDR_AUTHDATA   = 7'h30;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4,
        CMDERR_BUS        = 3'd5,
        CMDERR_OTHER      = 3'd7
    } cmderr_e;

    // True when addr falls inside the data0..dataN-1 window.
    function automatic logic is_data_addr(input logic [ADDR_W-1:0] addr, input int unsigned nb);
        return (addr >= ADDR_DATA0) && (32'(addr) < 32'(ADDR_DATA0) + nb);
    endfunction

endpackage

// File: rtl/dmi_abstract_cmd.sv
// Abstract command sequencer: latches command words, handshakes them to the hart, tracks busy/cmderr.
module dmi_abstract_cmd
    import dmi_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic        acs_we_i,
    input  logic [2:0]  cmderr_clr_i,
    input  logic        busy_err_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] cmd_o,
    input  logic        cmd_done_i,
    input  logic [2:0]  cmd_err_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o
);

    typedef enum logic [1:0] {CMD_IDLE, CMD_ISSUE, CMD_WAIT} cmd_state_e;

    cmd_state_e state;
    logic [2:0] cmderr_d;

    // Sticky error: write-1-to-clear, OR in completion errors, flag BUSY on the first violation.
    always_comb begin
        cmderr_d = cmderr_o;
        if (acs_we_i) cmderr_d = cmderr_d & ~cmderr_clr_i;
        if (state == CMD_WAIT && cmd_done_i) cmderr_d = cmderr_d | cmd_err_i;
        if (busy_err_i && cmderr_o == CMDERR_NONE) cmderr_d = cmderr_d | CMDERR_BUSY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state       <= CMD_IDLE;
            cmd_valid_o <= 1'b0;
            cmd_o       <= '0;
            busy_o      <= 1'b0;
            cmderr_o    <= CMDERR_NONE;
        end else begin
            cmderr_o <= cmderr_d;
            case (state)
                CMD_IDLE: begin
                    if (cmd_we_i && cmderr_o == CMDERR_NONE) begin
                        cmd_o       <= cmd_wdata_i;
                        busy_o      <= 1'b1;
                        cmd_valid_o <= 1'b1;
                        state       <= CMD_ISSUE;
                    end
                end
                CMD_ISSUE: begin
                    if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        state       <= CMD_WAIT;
                    end
                end
                CMD_WAIT: begin
                    if (cmd_done_i) begin
                        busy_o <= 1'b0;
                        state  <= CMD_IDLE;
                    end
                end
                default: state <= CMD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmi_responder.sv
// DMI request/response front end of the debug module with hart control registers.
// Optional authentication gate is built when DMI_AUTH_EN is defined.
module dmi_responder
    import dmi_responder_pkg::*;
#(
    parameter int unsigned NB_DATA = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    input  logic        halted_i,
    output logic        debug_req_o,
    output logic        resume_o,
    output logic        ndmreset_o,
    output logic        dmactive_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] cmd_o,
    input  logic        cmd_done_i,
    input  logic [2:0]  cmd_err_i
`ifdef DMI_AUTH_EN
    ,
    input  logic [31:0] auth_key_i
`endif
);

    typedef enum logic {S_IDLE, S_RESP} resp_state_e;

    resp_state_e       state;
    logic [31:0]       data_q [NB_DATA];
    logic              resumeack;
    logic              resume_pend;
    logic              authenticated;
    logic              busy;
    logic [2:0]        cmderr;

    logic              accept;
    logic              acc_rd;
    logic              acc_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy_viol;
    logic              wr_ok;
    logic              dmctl_wr;
    logic [31:0]       rdata;
    dmi_resp_t         resp_d;

`ifdef DMI_AUTH_EN
    logic auth_q;
    assign authenticated = auth_q;
`else
    assign authenticated = 1'b1;
`endif

    assign accept = dmi_req_valid_i && dmi_req_ready_o;
    assign addr   = dmi_req_i.addr;
    assign wdata  = dmi_req_i.data;
    assign acc_rd = accept && (dmi_req_i.op == OP_READ);
    assign acc_wr = accept && (dmi_req_i.op == OP_WRITE);

    // Accesses that would disturb a running abstract command are bounced.
    assign busy_viol = busy && (acc_rd || acc_wr) &&
                       (is_data_addr(addr, NB_DATA) || addr == ADDR_COMMAND ||
                        (acc_wr && addr == ADDR_ABSTRACTCS));
    assign wr_ok    = acc_wr && dmactive_o && authenticated && !busy_viol;
    assign dmctl_wr = acc_wr && (addr == ADDR_DMCONTROL);

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_DMCONTROL:  rdata = {debug_req_o, 29'b0, ndmreset_o, dmactive_o};
            ADDR_DMSTATUS:   rdata = {14'b0, resumeack, resumeack, 4'b0, !halted_i, !halted_i,
                                      halted_i, halted_i, authenticated, 3'b0, 4'd2};
            ADDR_ABSTRACTCS: rdata = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'(NB_DATA)};
            default: begin
                for (int unsigned i = 0; i < NB_DATA; i++) begin
                    if (addr == ADDR_DATA0 + 7'(i)) rdata = data_q[i];
                end
            end
        endcase
        if (!authenticated && addr != ADDR_DMSTATUS) rdata = '0;
    end

    always_comb begin
        resp_d.resp = RESP_OK;
        resp_d.data = '0;
        if (dmi_req_i.op == OP_RSVD) begin
            resp_d.resp = RESP_FAILED;
        end else if (busy_viol) begin
            resp_d.resp = RESP_BUSY;
        end else if (dmi_req_i.op == OP_READ) begin
            resp_d.data = rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            dmi_req_ready_o  <= 1'b0;
            dmi_resp_valid_o <= 1'b0;
            dmi_resp_o       <= '0;
            debug_req_o      <= 1'b0;
            resume_o         <= 1'b0;
            ndmreset_o       <= 1'b0;
            dmactive_o       <= 1'b0;
            resumeack        <= 1'b0;
            resume_pend      <= 1'b0;
            for (int unsigned i = 0; i < NB_DATA; i++) data_q[i] <= '0;
`ifdef DMI_AUTH_EN
            auth_q           <= 1'b0;
`endif
        end else begin
            resume_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    dmi_req_ready_o <= 1'b1;
                    if (accept) begin
                        state            <= S_RESP;
                        dmi_req_ready_o  <= 1'b0;
                        dmi_resp_valid_o <= 1'b1;
                        dmi_resp_o       <= resp_d;
                    end
                end
                S_RESP: begin
                    if (dmi_resp_ready_i) begin
                        state            <= S_IDLE;
                        dmi_resp_valid_o <= 1'b0;
                        dmi_req_ready_o  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Ack once the hart is seen running after the resume pulse.
            if (resume_pend && !resume_o && !halted_i) begin
                resumeack   <= 1'b1;
                resume_pend <= 1'b0;
            end

            if (!dmactive_o) begin
                debug_req_o <= 1'b0;
                ndmreset_o  <= 1'b0;
                resumeack   <= 1'b0;
                resume_pend <= 1'b0;
                for (int unsigned i = 0; i < NB_DATA; i++) data_q[i] <= '0;
            end

            // A write that sets dmactive may carry the other control fields with it.
            if (dmctl_wr) begin
                dmactive_o <= wdata[0];
                if (authenticated && wdata[0]) begin
                    debug_req_o <= wdata[31];
                    ndmreset_o  <= wdata[1];
                    if (wdata[30] && halted_i) begin
                        resume_o    <= 1'b1;
                        resumeack   <= 1'b0;
                        resume_pend <= 1'b1;
                    end
                end else begin
                    debug_req_o <= 1'b0;
                    ndmreset_o  <= 1'b0;
                end
            end

            for (int unsigned i = 0; i < NB_DATA; i++) begin
                if (wr_ok && addr == ADDR_DATA0 + 7'(i)) data_q[i] <= wdata;
            end

`ifdef DMI_AUTH_EN
            if (!dmactive_o) begin
                auth_q <= 1'b0;
            end else if (acc_wr && addr == ADDR_AUTHDATA && wdata == auth_key_i) begin
                auth_q <= 1'b1;
            end
`endif
        end
    end

    dmi_abstract_cmd u_cmd (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (!dmactive_o),
        .cmd_we_i     (wr_ok && addr == ADDR_COMMAND),
        .cmd_wdata_i  (wdata),
        .acs_we_i     (wr_ok && addr == ADDR_ABSTRACTCS),
        .cmderr_clr_i (wdata[10:8]),
        .busy_err_i   (busy_viol),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_o        (cmd_o),
        .cmd_done_i   (cmd_done_i),
        .cmd_err_i    (cmd_err_i),
        .busy_o       (busy),
        .cmderr_o     (cmderr)
    );

endmodule

// File: tb/tb_dmi_responder.sv
// Directed scoreboard bench for dmi_responder; covers the auth gate when DMI_AUTH_EN is defined.
module tb_dmi_responder;
    import dmi_responder_pkg::*;

`ifdef DMI_AUTH_EN
    localparam bit AUTH = 1'b1;
`else
    localparam bit AUTH = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    dmi_req_t    req;
    logic        req_valid;
    logic        req_ready;
    dmi_resp_t   dmi_resp;
    logic        resp_valid;
    logic        resp_ready;
    logic        halted;
    logic        debug_req;
    logic        resume;
    logic        ndmreset;
    logic        dmactive;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd;
    logic        cmd_done;
    logic [2:0]  cmd_err;
    logic [31:0] auth_key;

    int   total = 0;
    int   bad = 0;
    int   resume_cnt = 0;
    int   resume_snap;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (resume === 1'b1) resume_cnt <= resume_cnt + 1;

    dmi_responder #(.NB_DATA(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dmi_req_i        (req),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_resp_o       (dmi_resp),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .halted_i         (halted),
        .debug_req_o      (debug_req),
        .resume_o         (resume),
        .ndmreset_o       (ndmreset),
        .dmactive_o       (dmactive),
        .cmd_valid_o      (cmd_valid),
        .cmd_ready_i      (cmd_ready),
        .cmd_o            (cmd),
        .cmd_done_i       (cmd_done),
        .cmd_err_i        (cmd_err)
`ifdef DMI_AUTH_EN
        ,
        .auth_key_i       (auth_key)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DMI transaction; the response is held unacknowledged for 'hold' cycles.
    task automatic xact(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                        input logic [1:0] er, input logic [31:0] ed, input int hold);
        exp_t      e;
        dmi_resp_t snap;
        int        n;
        e.resp = er;
        e.data = ed;
        exp_q.push_back(e);
        @(negedge clk);
        req.addr  = a;
        req.op    = op;
        req.data  = wd;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_latency", 64'(n), 64'd0);
        e = exp_q.pop_front();
        chk($sformatf("resp_code@%0h", a), 64'(dmi_resp.resp), 64'(e.resp));
        chk($sformatf("resp_data@%0h", a), 64'(dmi_resp.data), 64'(e.data));
        snap = dmi_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_payload", 64'(dmi_resp), 64'(snap));
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_no_accept", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic cmd_handshake();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic cmd_finish(input logic [2:0] err);
        @(negedge clk);
        cmd_done = 1'b1;
        cmd_err  = err;
        @(negedge clk);
        cmd_done = 1'b0;
        cmd_err  = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req        = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        halted     = 1'b0;
        cmd_ready  = 1'b0;
        cmd_done   = 1'b0;
        cmd_err    = 3'd0;
        auth_key   = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_outputs", 64'({debug_req, resume, ndmreset, dmactive, cmd_valid}), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        xact(OP_READ, ADDR_DMSTATUS, 32'd0, RESP_OK, AUTH ? 32'h00000C02 : 32'h00000C82, 0);

`ifdef DMI_AUTH_EN
        xact(OP_WRITE, ADDR_AUTHDATA, 32'h12345678, RESP_OK, 32'd0, 0);
        xact(OP_READ, ADDR_DMSTATUS, 32'd0, RESP_OK, 32'h00000C02, 0);
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h80000001, RESP_OK, 32'd0, 0);
        chk("auth_dmactive", 64'(dmactive), 64'd1);
        chk("auth_haltreq_blocked", 64'(debug_req), 64'd0);
        xact(OP_READ, ADDR_DMCONTROL, 32'd0, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, ADDR_AUTHDATA, 32'hDEADBEEF, RESP_OK, 32'd0, 0);
        xact(OP_READ, ADDR_DMSTATUS, 32'd0, RESP_OK, 32'h00000C82, 0);
        xact(OP_READ, ADDR_AUTHDATA, 32'd0, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h80000001, RESP_OK, 32'd0, 0);
        chk("auth_haltreq_taken", 64'(debug_req), 64'd1);
`endif

        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00000002, 0);
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h80000001, RESP_OK, 32'd0, 0);
        chk("debug_req", 64'(debug_req), 64'd1);
        chk("dmactive", 64'(dmactive), 64'd1);
        xact(OP_READ, ADDR_DMCONTROL, 32'd0, RESP_OK, 32'h80000001, 5);

        xact(OP_WRITE, 7'h04, 32'h11112222, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, 7'h05, 32'h33334444, RESP_OK, 32'd0, 0);
        xact(OP_READ, 7'h04, 32'd0, RESP_OK, 32'h11112222, 0);
        xact(OP_READ, 7'h05, 32'd0, RESP_OK, 32'h33334444, 0);
        xact(OP_READ, 7'h06, 32'd0, RESP_OK, 32'd0, 0);

        xact(OP_WRITE, ADDR_COMMAND, 32'h00221000, RESP_OK, 32'd0, 0);
        chk("cmd_valid_rise", 64'(cmd_valid), 64'd1);
        chk("cmd_word", 64'(cmd), 64'h00221000);
        xact(OP_WRITE, 7'h04, 32'hBAD0BAD0, RESP_BUSY, 32'd0, 0);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00001102, 0);
        xact(OP_READ, ADDR_COMMAND, 32'd0, RESP_BUSY, 32'd0, 0);
        chk("cmd_valid_held", 64'(cmd_valid), 64'd1);
        cmd_handshake();
        chk("cmd_valid_drop", 64'(cmd_valid), 64'd0);
        cmd_finish(3'd0);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00000102, 0);
        xact(OP_WRITE, ADDR_ABSTRACTCS, 32'h00000700, RESP_OK, 32'd0, 0);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00000002, 0);
        xact(OP_READ, 7'h04, 32'd0, RESP_OK, 32'h11112222, 0);

        xact(OP_WRITE, ADDR_COMMAND, 32'h00000001, RESP_OK, 32'd0, 0);
        cmd_handshake();
        cmd_finish(3'd3);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00000302, 0);
        xact(OP_WRITE, ADDR_COMMAND, 32'h00000005, RESP_OK, 32'd0, 0);
        chk("cmd_blocked_valid", 64'(cmd_valid), 64'd0);
        chk("cmd_blocked_word", 64'(cmd), 64'h00000001);
        xact(OP_WRITE, ADDR_ABSTRACTCS, 32'h00000700, RESP_OK, 32'd0, 0);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, 32'h00000002, 0);

        xact(OP_RSVD, ADDR_DMCONTROL, 32'h00000000, RESP_FAILED, 32'd0, 0);
        xact(OP_READ, ADDR_DMCONTROL, 32'd0, RESP_OK, 32'h80000001, 0);
        xact(OP_READ, 7'h7F, 32'd0, RESP_OK, 32'd0, 0);
        xact(OP_NOP, ADDR_DMCONTROL, 32'h12345678, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, 7'h7F, 32'hFFFFFFFF, RESP_OK, 32'd0, 0);

        @(negedge clk);
        halted = 1'b1;
        resume_snap = resume_cnt;
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h40000001, RESP_OK, 32'd0, 0);
        chk("resume_pulse_count", 64'(resume_cnt - resume_snap), 64'd1);
        chk("haltreq_cleared", 64'(debug_req), 64'd0);
        xact(OP_READ, ADDR_DMSTATUS, 32'd0, RESP_OK, 32'h00000382, 0);
        @(negedge clk);
        halted = 1'b0;
        xact(OP_READ, ADDR_DMSTATUS, 32'd0, RESP_OK, 32'h00030C82, 0);

        xact(OP_WRITE, ADDR_COMMAND, 32'h00000033, RESP_OK, 32'd0, 0);
        cmd_handshake();
        @(negedge clk);
        req.addr  = ADDR_DMSTATUS;
        req.op    = OP_READ;
        req.data  = 32'd0;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_resp_pending", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_resp_dropped", 64'(resp_valid), 64'd0);
        chk("midrst_outputs", 64'({cmd_valid, dmactive, debug_req, req_ready}), 64'd0);
        cmd_finish(3'd5);
        xact(OP_READ, ADDR_ABSTRACTCS, 32'd0, RESP_OK, AUTH ? 32'd0 : 32'h00000002, 0);

        xact(OP_WRITE, ADDR_DMCONTROL, 32'h00000001, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, 7'h04, 32'h0000AAAA, RESP_OK, 32'd0, 0);
        xact(OP_READ, 7'h04, 32'd0, RESP_OK, AUTH ? 32'd0 : 32'h0000AAAA, 0);
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h00000000, RESP_OK, 32'd0, 0);
        chk("deactivated", 64'(dmactive), 64'd0);
        xact(OP_WRITE, 7'h04, 32'h0000BBBB, RESP_OK, 32'd0, 0);
        xact(OP_WRITE, ADDR_DMCONTROL, 32'h00000001, RESP_OK, 32'd0, 0);
        xact(OP_READ, 7'h04, 32'd0, RESP_OK, 32'd0, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
